// File: rtl/hack_ram_pkg.sv
// Shared types and constants for the hack RAM arbiter and its helpers.
package hack_ram_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } arb_state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 13;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone eligible requester wins outright; on a tie
// the requester that did not win last time is chosen.
module rr_arbiter2
  import hack_ram_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |eligible;
    grant_id    = REQ_A;
    if (eligible == 2'b11) begin
      grant_id = ~last_grant;
    end else if (eligible[REQ_B]) begin
      grant_id = REQ_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one async-read single-port RAM between requesters A and B using a
// two-state controller. Optional conflict counter: RAM_ARB_CONFLICT_CNT_EN.
module ram_arbiter
  import hack_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_load,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_dataIn,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_dataOut,
  input  logic                  b_req,
  input  logic                  b_load,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_dataIn,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_dataOut,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_dataIn,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_dataOut,
  output logic                  busy
`ifdef RAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]           conflict_count
`endif
);

  arb_state_e            state_q;
  logic                  lastGrant_q;
  logic                  winner_q;
  logic [ADDR_WIDTH-1:0] ramAddress_q;
  logic [DATA_WIDTH-1:0] ramDataIn_q;
  logic                  ramLoad_q;
  logic                  aAck_q;
  logic                  bAck_q;
  logic [DATA_WIDTH-1:0] aDataOut_q;
  logic [DATA_WIDTH-1:0] bDataOut_q;
  logic                  busy_q;

  logic [1:0]            eligible;
  logic                  grantValid;
  logic                  grantId;
  logic [ADDR_WIDTH-1:0] ramAddress_d;
  logic [DATA_WIDTH-1:0] ramDataIn_d;
  logic                  ramLoad_d;

  // A requester is masked during its own ack cycle so a held req is not served twice.
  assign eligible = {b_req & ~bAck_q, a_req & ~aAck_q};

  rr_arbiter2 u_rr (
    .eligible    (eligible),
    .last_grant  (lastGrant_q),
    .grant_valid (grantValid),
    .grant_id    (grantId)
  );

  assign ramAddress_d = (grantId == REQ_B) ? b_address : a_address;
  assign ramDataIn_d  = (grantId == REQ_B) ? b_dataIn  : a_dataIn;
  assign ramLoad_d    = (grantId == REQ_B) ? b_load    : a_load;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      lastGrant_q  <= REQ_B;
      winner_q     <= REQ_A;
      ramAddress_q <= '0;
      ramDataIn_q  <= '0;
      ramLoad_q    <= 1'b0;
      aAck_q       <= 1'b0;
      bAck_q       <= 1'b0;
      aDataOut_q   <= '0;
      bDataOut_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      aAck_q <= 1'b0;
      bAck_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ramLoad_q <= 1'b0;
          if (grantValid) begin
            winner_q     <= grantId;
            lastGrant_q  <= grantId;
            ramAddress_q <= ramAddress_d;
            ramDataIn_q  <= ramDataIn_d;
            ramLoad_q    <= ramLoad_d;
            busy_q       <= 1'b1;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          // For a write this captures the pre-write word; requesters ignore it.
          if (winner_q == REQ_A) begin
            aDataOut_q <= ram_dataOut;
            aAck_q     <= 1'b1;
          end else begin
            bDataOut_q <= ram_dataOut;
            bAck_q     <= 1'b1;
          end
          ramLoad_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign a_ack       = aAck_q;
  assign b_ack       = bAck_q;
  assign a_dataOut   = aDataOut_q;
  assign b_dataOut   = bDataOut_q;
  assign ram_address = ramAddress_q;
  assign ram_dataIn  = ramDataIn_q;
  assign ram_load    = ramLoad_q;
  assign busy        = busy_q;

`ifdef RAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflictCnt_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      conflictCnt_q <= '0;
    end else if (state_q == IDLE && eligible == 2'b11 && conflictCnt_q != 16'hFFFF) begin
      conflictCnt_q <= conflictCnt_q + 16'd1;
    end
  end

  assign conflict_count = conflictCnt_q;
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port RAM (async read, write on CLK edge when load is high) between two requesters.
- Requester A is the CPU data port. Requester B is a DMA/loader or screen-refresh port.
- Two-state controller with round-robin arbitration, registered RAM drive, registered read data and a one-cycle ack pulse per access.
- Sits between the requesters and the RAM instance. RAM ports connect 1:1 to the ram_* ports.

Parameters:
- DATA_WIDTH, 16, word width of RAM and requester data.
- ADDR_WIDTH, 13, word address width.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- a_req  in  1  A requests an access; held with a_load/a_address/a_dataIn stable until a_ack.
- a_load  in  1  1 = write, 0 = read.
- a_address  in  ADDR_WIDTH  A word address.
- a_dataIn  in  DATA_WIDTH  A write data.
- a_ack  out  1  one-cycle pulse: A access complete.
- a_dataOut  out  DATA_WIDTH  A read data; valid while a_ack=1, held until next A ack.
- b_req, b_load, b_address, b_dataIn, b_ack, b_dataOut  same as A for requester B.
- ram_address  out  ADDR_WIDTH  to RAM address.
- ram_dataIn  out  DATA_WIDTH  to RAM dataIn.
- ram_load  out  1  to RAM load.
- ram_dataOut  in  DATA_WIDTH  from RAM dataOut (combinational read).
- busy  out  1  high in ACCESS state.

Behaviour:
- Reset values: state=IDLE; a_ack=b_ack=0; a_dataOut=b_dataOut=0; ram_address=0; ram_dataIn=0; ram_load=0; busy=0; last_grant=B, so A wins the first tie.
- States: IDLE, ACCESS. All outputs are registered.
- Request masking in IDLE: eligible_x = x_req & ~x_ack. A request is ignored in the cycle its own ack is high, because the requester drops or replaces req at that edge.
- IDLE, no eligible request: stay in IDLE; ram_load=0.
- IDLE, one eligible request: grant it.
- IDLE, both eligible: grant the requester that is not last_grant.
- On grant: latch winner id; ram_address <= x_address; ram_dataIn <= x_dataIn; ram_load <= x_load; last_grant <= winner; go to ACCESS.
- ACCESS (exactly one cycle):
  - RAM is driven by the registered outputs. A write commits at the closing edge.
  - At the closing edge: winner_dataOut <= ram_dataOut (for writes this captures the pre-write value; requesters ignore it); winner_ack <= 1; ram_load <= 0; go to IDLE.
- Acks are single-cycle pulses; the other requester's ack stays 0.
- Latency: req first seen in IDLE at cycle N → ACCESS at N+1 → ack and data at N+2.
- Peak throughput: one access per 2 cycles. With both requesters saturated, grants alternate A,B,A,B.
- Back-to-back: a requester may keep req high with new address/data in its ack cycle. That request is masked for that cycle and eligible in the following IDLE.
- Requester dropping req before ack: undefined use. The arbiter still completes the latched access and pulses ack.
- Reset in IDLE: no RAM effect.
- Reset in ACCESS: the RAM write at that edge still commits (ram_load was already high). The arbiter returns to reset values; no ack is issued.
- Addresses pass through unmodified; no wrap logic. The RAM depth defines the valid range.

Optional Feature:
- Macro: RAM_ARB_CONFLICT_CNT_EN.
- When defined:
  - Adds output conflict_count [15:0].
  - Increments by 1 in each IDLE cycle where both requesters are eligible.
  - Saturates at 16'hFFFF; reset to 0.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package hack_ram_pkg:
  - state enum {IDLE, ACCESS}.
  - Requester id constants REQ_A=0, REQ_B=1.
  - Default DATA_WIDTH/ADDR_WIDTH constants.
- Sub-module rr_arbiter2: combinational two-way round-robin pick.
  - Inputs: eligible[1:0], last_grant.
  - Outputs: grant_valid, grant_id.
  - Reused by future shared-resource blocks.

Test Plan:
- A write 0x1234 @0x0005 alone → grant at N, ram_load=1 only in N+1, a_ack pulse at N+2, b_ack=0. Then an A read @0x0005 → a_dataOut=0x1234 with a_ack.
- A and B both request reads from reset (A @0x0001, B @0x0002) → A acked first, B acked 2 cycles later; last_grant ends at B.
- Both held saturated with new addresses each ack for 8 accesses → grant order A,B,A,B,…; each ack exactly one cycle; no duplicate access to the same request.
- B writes 0xBEEF @0x1FFF while A reads @0x1FFF, A requesting one cycle later → B write commits first; A read returns 0xBEEF.
- Reset asserted during an ACCESS that writes 0x00AA @0x0010 → no ack; busy=0 next cycle; a subsequent read @0x0010 returns 0x00AA.
- With RAM_ARB_CONFLICT_CNT_EN: 5 simultaneous-eligibility IDLE cycles → conflict_count=5; forced to 0xFFFF it stays at 0xFFFF on the next conflict.
